// File: rtl/tdmrc_pkg.sv
// Shared constants, FSM state encodings and key configuration type for the
// e-TDMRC frame scheduler.
package tdmrc_pkg;

  localparam int FRAME_W = 40;
  localparam int BYTE_N  = 5;

  // Key configuration register addresses
  localparam logic [2:0] CFG_MASTER = 3'd0;
  localparam logic [2:0] CFG_SUB0   = 3'd1;
  localparam logic [2:0] CFG_SUB1   = 3'd2;
  localparam logic [2:0] CFG_SUB2   = 3'd3;
  localparam logic [2:0] CFG_SUB3   = 3'd4;

  // Scheduler FSM states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CRST = 3'd1;
  localparam logic [2:0] ST_ARB  = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  typedef struct packed {
    logic [31:0] master_key;
    logic [15:0] subkey0;
    logic [15:0] subkey1;
    logic [15:0] subkey2;
    logic [15:0] subkey3;
  } key_cfg_t;

  // Addresses 5..7 are not backed by a register.
  function automatic logic cfg_addr_valid(input logic [2:0] addr);
    return (addr <= CFG_SUB3);
  endfunction

  // Apply one configuration write to the key set; subkeys take the low half.
  function automatic key_cfg_t key_write(input key_cfg_t k, input logic [2:0] addr,
                                         input logic [31:0] d);
    key_cfg_t r;
    r = k;
    case (addr)
      CFG_MASTER: r.master_key = d;
      CFG_SUB0:   r.subkey0    = d[15:0];
      CFG_SUB1:   r.subkey1    = d[15:0];
      CFG_SUB2:   r.subkey2    = d[15:0];
      CFG_SUB3:   r.subkey3    = d[15:0];
      default:    r            = k;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tdmrc_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted requester
// and wraps, so every requester holding its request is served within NUM_REQ
// grants.
module tdmrc_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);

  // Candidate requester for each priority slot, highest priority first
  logic [ID_W-1:0] cand_idx [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = ID_W'((int'(last_id) + gi + 1) % NUM_REQ);
    end
  endgenerate

  // Pick the first requesting candidate in rotated priority order
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req[cand_idx[k]]) begin
        grant_any = 1'b1;
        grant_id  = cand_idx[k];
      end
    end
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

endmodule

// File: rtl/tdmrc_frame_scheduler.sv
// Shares one e-TDMRC cipher core between NUM_REQ frame requesters: holds the
// key set, arbitrates frames round-robin, streams each frame as five bytes to
// the core and returns the core result tagged with the requester id.
module tdmrc_frame_scheduler
  import tdmrc_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*FRAME_W-1:0] req_frame,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [FRAME_W-1:0]         rsp_cipher,
  output logic [FRAME_W-1:0]         rsp_plain,
  output logic                       rsp_err,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_addr,
  input  logic [31:0]                cfg_wdata,
  output logic                       cfg_ack,
  output logic                       busy,
  output logic                       core_rst,
  output logic [31:0]                core_master_key,
  output logic [15:0]                core_subkey0,
  output logic [15:0]                core_subkey1,
  output logic [15:0]                core_subkey2,
  output logic [15:0]                core_subkey3,
  output logic [7:0]                 core_data_in,
  output logic                       core_data_valid,
  input  logic                       core_done,
  input  logic [FRAME_W-1:0]         core_cipher,
  input  logic [FRAME_W-1:0]         core_plain
);

  localparam int              TMR_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      BYTE_LAST = 3'(BYTE_N - 1);

  logic [2:0]         state_reg;
  logic               crst_cnt_reg;
  logic [2:0]         byte_cnt_reg;
  logic [TMR_W-1:0]   timer_reg;
  key_cfg_t           key_reg;
  logic               key_dirty_reg;
  logic [ID_W-1:0]    rr_ptr_reg;
  logic [FRAME_W-1:0] frame_reg;
  logic [ID_W-1:0]    id_reg;
  logic [FRAME_W-1:0] rsp_cipher_reg;
  logic [FRAME_W-1:0] rsp_plain_reg;
  logic               rsp_err_reg;
  logic               cfg_ack_reg;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;

  // Per-requester view of the flattened frame bus
  logic [FRAME_W-1:0] frame_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_frame
      assign frame_arr[gi] = req_frame[gi*FRAME_W +: FRAME_W];
    end
  endgenerate

  tdmrc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .last_id   (rr_ptr_reg),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // Scheduler FSM, key registers and frame/response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      crst_cnt_reg   <= 1'b0;
      byte_cnt_reg   <= '0;
      timer_reg      <= '0;
      key_reg        <= '0;
      key_dirty_reg  <= 1'b1;
      rr_ptr_reg     <= '0;
      frame_reg      <= '0;
      id_reg         <= '0;
      rsp_cipher_reg <= '0;
      rsp_plain_reg  <= '0;
      rsp_err_reg    <= 1'b0;
      cfg_ack_reg    <= 1'b0;
    end else begin
      cfg_ack_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A config write takes the cycle; any pending request waits a cycle.
          if (cfg_we) begin
            if (cfg_addr_valid(cfg_addr)) begin
              key_reg       <= key_write(key_reg, cfg_addr, cfg_wdata);
              key_dirty_reg <= 1'b1;
              cfg_ack_reg   <= 1'b1;
            end
          end else if (|req_valid) begin
            crst_cnt_reg <= 1'b0;
            state_reg    <= key_dirty_reg ? ST_CRST : ST_ARB;
          end
        end
        ST_CRST: begin
          // Two cycles of core reset so the core reloads its key schedule
          if (crst_cnt_reg) begin
            key_dirty_reg <= 1'b0;
            state_reg     <= ST_ARB;
          end else begin
            crst_cnt_reg <= 1'b1;
          end
        end
        ST_ARB: begin
          if (grant_any) begin
            frame_reg    <= frame_arr[grant_id];
            id_reg       <= grant_id;
            rr_ptr_reg   <= grant_id;
            byte_cnt_reg <= '0;
            state_reg    <= ST_SEND;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_SEND: begin
          // Most significant byte goes first; shift the next one into place.
          frame_reg <= frame_reg << 8;
          if (byte_cnt_reg == BYTE_LAST) begin
            timer_reg <= '0;
            state_reg <= ST_WAIT;
          end else begin
            byte_cnt_reg <= byte_cnt_reg + 3'd1;
          end
        end
        ST_WAIT: begin
          // The core drops done on the first accepted byte, so any done here is fresh.
          if (core_done) begin
            rsp_cipher_reg <= core_cipher;
            rsp_plain_reg  <= core_plain;
            rsp_err_reg    <= 1'b0;
            state_reg      <= ST_RESP;
          end else if (timer_reg == TMR_LAST) begin
            rsp_cipher_reg <= '0;
            rsp_plain_reg  <= '0;
            rsp_err_reg    <= 1'b1;
            key_dirty_reg  <= 1'b1;
            state_reg      <= ST_RESP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy            = (state_reg != ST_IDLE);
  assign core_rst        = rst | (state_reg == ST_CRST);
  assign req_ready       = (state_reg == ST_ARB) ? grant : '0;
  assign core_data_valid = (state_reg == ST_SEND);
  assign core_data_in    = frame_reg[FRAME_W-1 -: 8];
  assign rsp_valid       = (state_reg == ST_RESP);
  assign rsp_id          = id_reg;
  assign rsp_cipher      = rsp_cipher_reg;
  assign rsp_plain       = rsp_plain_reg;
  assign rsp_err         = rsp_err_reg;
  assign cfg_ack         = cfg_ack_reg;
  assign core_master_key = key_reg.master_key;
  assign core_subkey0    = key_reg.subkey0;
  assign core_subkey1    = key_reg.subkey1;
  assign core_subkey2    = key_reg.subkey2;
  assign core_subkey3    = key_reg.subkey3;

endmodule

// File: tb/tb_tdmrc_frame_scheduler.sv
// Directed testbench for tdmrc_frame_scheduler with a behavioural core stub
// whose "cipher" is the received frame XOR 40'hA5A5A5A5A5.
module tb_tdmrc_frame_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 32;
  localparam int NCORE       = 3;

  logic               clk;
  logic               rst;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*40-1:0] req_frame;
  logic [NUM_REQ-1:0] req_ready;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [39:0]        rsp_cipher;
  logic [39:0]        rsp_plain;
  logic               rsp_err;
  logic               cfg_we;
  logic [2:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic               cfg_ack;
  logic               busy;
  logic               core_rst;
  logic [31:0]        core_master_key;
  logic [15:0]        core_subkey0, core_subkey1, core_subkey2, core_subkey3;
  logic [7:0]         core_data_in;
  logic               core_data_valid;
  logic               core_done;
  logic [39:0]        core_cipher;
  logic [39:0]        core_plain;

  int n_checks = 0;
  int n_fail   = 0;

  tdmrc_frame_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .ID_W        (ID_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_frame       (req_frame),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_cipher      (rsp_cipher),
    .rsp_plain       (rsp_plain),
    .rsp_err         (rsp_err),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .cfg_ack         (cfg_ack),
    .busy            (busy),
    .core_rst        (core_rst),
    .core_master_key (core_master_key),
    .core_subkey0    (core_subkey0),
    .core_subkey1    (core_subkey1),
    .core_subkey2    (core_subkey2),
    .core_subkey3    (core_subkey3),
    .core_data_in    (core_data_in),
    .core_data_valid (core_data_valid),
    .core_done       (core_done),
    .core_cipher     (core_cipher),
    .core_plain      (core_plain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stub: collect 5 bytes, raise done NCORE cycles later, hold until next byte
  logic [39:0] sb_shift;
  logic [2:0]  sb_cnt;
  int          sb_dly;
  logic        sb_done;
  logic        stub_mute;

  always @(posedge clk) begin
    if (core_rst) begin
      sb_cnt  <= 3'd0;
      sb_dly  <= 0;
      sb_done <= 1'b0;
    end else if (core_data_valid) begin
      sb_shift <= {sb_shift[31:0], core_data_in};
      sb_done  <= 1'b0;
      if (sb_cnt == 3'd4) begin
        sb_cnt <= 3'd0;
        sb_dly <= NCORE;
      end else begin
        sb_cnt <= sb_cnt + 3'd1;
      end
    end else if (sb_dly != 0) begin
      sb_dly <= sb_dly - 1;
      if (sb_dly == 1 && !stub_mute) sb_done <= 1'b1;
    end
  end

  assign core_done   = sb_done;
  assign core_plain  = sb_shift;
  assign core_cipher = sb_shift ^ 40'hA5A5A5A5A5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, output logic got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int budget, output logic got, output int cycles);
    got    = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cycles++;
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        $display("rsp id=%0d cipher=%h plain=%h err=%0b", rsp_id, rsp_cipher, rsp_plain, rsp_err);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_frame = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_wdata = '0; stub_mute = 1'b0;
    tick(); tick();
    n_checks++;
    if ({busy, rsp_valid, cfg_ack, core_data_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {busy, rsp_valid, cfg_ack, core_data_valid});
    end
    n_checks++;
    if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
    n_checks++;
    if (req_ready !== 4'b0000 || core_master_key !== 32'h0) begin
      n_fail++; $display("FAIL reset_ready_key: got %b/%h expected 0000/0", req_ready, core_master_key);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (core_rst !== 1'b0) begin n_fail++; $display("FAIL release_core_rst: got %b expected 0", core_rst); end
  endtask

  task automatic test_cfg();
    logic [31:0] wd [5];
    int acks;
    wd[0] = 32'h12345678; wd[1] = 32'h0011; wd[2] = 32'h0022; wd[3] = 32'h0033; wd[4] = 32'h0044;
    acks = 0;
    for (int a = 0; a < 5; a++) begin
      cfg_we = 1'b1; cfg_addr = 3'(a); cfg_wdata = wd[a];
      tick();
      cfg_we = 1'b0;
      if (cfg_ack === 1'b1) acks++;
      $display("cfg addr=%0d data=%h ack=%b", a, wd[a], cfg_ack);
      tick();
    end
    n_checks++;
    if (acks != 5) begin n_fail++; $display("FAIL cfg_ack_count: got %0d expected 5", acks); end
    n_checks++;
    if (core_master_key !== 32'h12345678) begin
      n_fail++; $display("FAIL cfg_master: got %h expected 12345678", core_master_key);
    end
    n_checks++;
    if ({core_subkey0, core_subkey1, core_subkey2, core_subkey3} !== 64'h0011_0022_0033_0044) begin
      n_fail++; $display("FAIL cfg_subkeys: got %h %h %h %h expected 0011 0022 0033 0044",
                         core_subkey0, core_subkey1, core_subkey2, core_subkey3);
    end
  endtask

  task automatic test_single_frame();
    logic got;
    int cyc;
    req_frame[2*40 +: 40] = 40'h4142434445;
    req_valid = 4'b0100;
    tick();
    n_checks++;
    if ({core_rst, busy} !== 2'b11) begin n_fail++; $display("FAIL crst_cycle1: got %b expected 11", {core_rst, busy}); end
    tick();
    n_checks++;
    if (core_rst !== 1'b1) begin n_fail++; $display("FAIL crst_cycle2: got %b expected 1", core_rst); end
    tick();
    n_checks++;
    if (req_ready !== 4'b0100 || core_rst !== 1'b0) begin
      n_fail++; $display("FAIL grant_2: got ready=%b core_rst=%b expected 0100/0", req_ready, core_rst);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) req_valid = '0;
      n_checks++;
      if ({core_data_valid, core_data_in} !== {1'b1, 8'h41 + 8'(i)}) begin
        n_fail++; $display("FAIL send_byte%0d: got v=%b d=%h expected v=1 d=%h", i, core_data_valid, core_data_in, 8'h41 + 8'(i));
      end
    end
    wait_rsp(60, got, cyc);
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL rsp_arrive: got %b expected 1", got); end
    n_checks++;
    if (rsp_id !== 2'd2 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rsp_id_err: got %0d/%b expected 2/0", rsp_id, rsp_err);
    end
    n_checks++;
    if (rsp_plain !== 40'h4142434445) begin n_fail++; $display("FAIL rsp_plain: got %h expected 4142434445", rsp_plain); end
    n_checks++;
    if (rsp_cipher !== 40'hE4E7E6E1E0) begin n_fail++; $display("FAIL rsp_cipher: got %h expected e4e7e6e1e0", rsp_cipher); end
    tick();
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rsp_pulse_end: got %b expected 00", {rsp_valid, busy}); end
  endtask

  task automatic test_round_robin();
    int exp_id [5];
    logic [7:0] b;
    logic [3:0] oh;
    logic got;
    int cyc;
    exp_id[0] = 1; exp_id[1] = 2; exp_id[2] = 3; exp_id[3] = 0; exp_id[4] = 1;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      b = 8'hA0 + 8'(i);
      req_frame[i*40 +: 40] = {b, b, b, b, b};
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ready(20, got);
      oh = 4'b0001 << exp_id[k];
      n_checks++;
      if (got !== 1'b1 || req_ready !== oh) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, oh);
      end
      tick();
      if (k == 4) req_valid = '0;
      wait_rsp(60, got, cyc);
      b = 8'hA0 + 8'(exp_id[k]);
      n_checks++;
      if (got !== 1'b1 || rsp_id !== 2'(exp_id[k]) || rsp_plain !== {b, b, b, b, b}) begin
        n_fail++; $display("FAIL rr_rsp%0d: got id=%0d plain=%h expected id=%0d plain=%h",
                           k, rsp_id, rsp_plain, exp_id[k], {b, b, b, b, b});
      end
    end
  endtask

  task automatic test_cfg_while_busy();
    logic got;
    int cyc;
    tick();
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'hCAFEBABE;
    tick();
    cfg_we = 1'b0;
    n_checks++;
    if (cfg_ack !== 1'b1 || core_master_key !== 32'hCAFEBABE) begin
      n_fail++; $display("FAIL cfg_idle_write: got ack=%b key=%h expected 1/cafebabe", cfg_ack, core_master_key);
    end
    req_frame[0 +: 40] = 40'h0102030405;
    req_valid = 4'b0001;
    wait_ready(20, got);
    tick();
    req_valid = '0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'hDEADBEEF;
    tick();
    cfg_we = 1'b0;
    n_checks++;
    if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL cfg_busy_ack: got %b expected 0", cfg_ack); end
    n_checks++;
    if (core_master_key !== 32'hCAFEBABE) begin
      n_fail++; $display("FAIL cfg_busy_key: got %h expected cafebabe", core_master_key);
    end
    wait_rsp(60, got, cyc);
    n_checks++;
    if (got !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL busy_frame_rsp: got %b id=%0d expected 1 id=0", got, rsp_id); end
    tick();
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 32'h0000_5555;
    req_valid = 4'b0001;
    tick();
    cfg_we = 1'b0;
    n_checks++;
    if ({cfg_ack, busy} !== 2'b10 || core_subkey0 !== 16'h5555) begin
      n_fail++; $display("FAIL cfg_wins: got ack=%b busy=%b sk0=%h expected 1/0/5555", cfg_ack, busy, core_subkey0);
    end
    tick();
    n_checks++;
    if ({core_rst, busy} !== 2'b11) begin n_fail++; $display("FAIL cfg_then_crst: got %b expected 11", {core_rst, busy}); end
    wait_ready(20, got);
    tick();
    req_valid = '0;
    wait_rsp(60, got, cyc);
    n_checks++;
    if (got !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL post_cfg_rsp: got %b err=%b expected 1/0", got, rsp_err); end
  endtask

  task automatic test_timeout();
    logic got;
    int cyc;
    tick();
    stub_mute = 1'b1;
    req_frame[3*40 +: 40] = 40'h0A0B0C0D0E;
    req_valid = 4'b1000;
    wait_ready(20, got);
    n_checks++;
    if (got !== 1'b1 || req_ready !== 4'b1000) begin n_fail++; $display("FAIL to_grant: got %b expected 1000", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(80, got, cyc);
    n_checks++;
    if (got !== 1'b1 || cyc + 1 != 5 + TIMEOUT_CYC + 1) begin
      n_fail++; $display("FAIL to_latency: got %0d cycles (seen=%b) expected %0d", cyc + 1, got, 5 + TIMEOUT_CYC + 1);
    end
    n_checks++;
    if (rsp_err !== 1'b1 || rsp_id !== 2'd3) begin n_fail++; $display("FAIL to_err: got err=%b id=%0d expected 1/3", rsp_err, rsp_id); end
    n_checks++;
    if (rsp_cipher !== 40'h0 || rsp_plain !== 40'h0) begin
      n_fail++; $display("FAIL to_data: got %h/%h expected 0/0", rsp_cipher, rsp_plain);
    end
    stub_mute = 1'b0;
    tick();
    req_valid = 4'b1000;
    tick();
    n_checks++;
    if (core_rst !== 1'b1) begin n_fail++; $display("FAIL to_recover_crst: got %b expected 1", core_rst); end
    wait_ready(20, got);
    tick();
    req_valid = '0;
    wait_rsp(60, got, cyc);
    n_checks++;
    if (got !== 1'b1 || rsp_err !== 1'b0 || rsp_cipher !== 40'hAFAEA9A8AB) begin
      n_fail++; $display("FAIL to_recover_rsp: got %b err=%b cipher=%h expected 1/0/afaea9a8ab", got, rsp_err, rsp_cipher);
    end
  endtask

  task automatic test_rst_in_wait();
    logic got;
    logic saw_rsp;
    int cyc;
    tick();
    stub_mute = 1'b1;
    req_frame[1*40 +: 40] = 40'h1122334455;
    req_valid = 4'b0010;
    wait_ready(20, got);
    tick();
    req_valid = '0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if ({busy, core_data_valid} !== 2'b10) begin n_fail++; $display("FAIL in_wait: got %b expected 10", {busy, core_data_valid}); end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, rsp_valid, core_rst} !== 3'b001) begin
      n_fail++; $display("FAIL rst_wait_abort: got %b expected 001", {busy, rsp_valid, core_rst});
    end
    rst = 1'b0;
    stub_mute = 1'b0;
    saw_rsp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid === 1'b1) saw_rsp = 1'b1;
    end
    n_checks++;
    if (saw_rsp !== 1'b0) begin n_fail++; $display("FAIL rst_no_rsp: got %b expected 0", saw_rsp); end
    req_valid = 4'b0010;
    tick();
    n_checks++;
    if (core_rst !== 1'b1) begin n_fail++; $display("FAIL rst_then_crst: got %b expected 1", core_rst); end
    wait_ready(20, got);
    tick();
    req_valid = '0;
    wait_rsp(60, got, cyc);
    n_checks++;
    if (got !== 1'b1 || rsp_id !== 2'd1 || rsp_plain !== 40'h1122334455) begin
      n_fail++; $display("FAIL rst_next_rsp: got %b id=%0d plain=%h expected 1/1/1122334455", got, rsp_id, rsp_plain);
    end
  endtask

  initial begin
    test_reset();
    test_cfg();
    test_single_frame();
    test_round_robin();
    test_cfg_while_busy();
    test_timeout();
    test_rst_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
